// File: rtl/sub64_serial_if.sv
// Handshake and operand/result bundle for the slice-serial subtractor.
interface sub64_serial_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (output start, op1, op2, input diff, borrow, busy, done);
  modport slave  (input start, op1, op2, output diff, borrow, busy, done);
endinterface

// File: rtl/sub64_serial.sv
// Slice-serial subtractor: op1 - op2 computed SLICE bits per clock through one
// ripple slice; the result and borrow are published together with a done pulse.

module sub64_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);
  logic [SLICE:0] cy;

  assign cy[0] = ci;
  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end
  assign co = cy[SLICE];
endmodule

module sub64_serial #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic         clock,
  input  logic         reset,
  sub64_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("sub64_serial: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a, b, shadow, shadow_nx, diff_q;
  logic [KW-1:0]    k;
  logic             carry, borrow_q;
  logic [SLICE-1:0] sa, sb, s;
  logic             c, accept, last;

  // Subtraction as a + ~b + 1: b is stored inverted and carry starts at 1.
  assign sa   = a[k*SLICE +: SLICE];
  assign sb   = b[k*SLICE +: SLICE];
  assign last = (k == KW'(NSLICE - 1));

  sub64_slice #(.SLICE(SLICE)) u_slice (
    .a  (sa),
    .b  (sb),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  // Merging the current slice lets the last edge publish the full result.
  always_comb begin
    shadow_nx = shadow;
    shadow_nx[k*SLICE +: SLICE] = s;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN:  if (last) state_nx = DONE;
      DONE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end else begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a        <= '0;
      b        <= '0;
      shadow   <= '0;
      diff_q   <= '0;
      k        <= '0;
      carry    <= 1'b0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a     <= bus.op1;
      b     <= ~bus.op2;
      carry <= 1'b1;
      k     <= '0;
    end else if (state == RUN) begin
      shadow <= shadow_nx;
      carry  <= c;
      k      <= k + 1'b1;
      if (last) begin
        diff_q   <= shadow_nx;
        borrow_q <= ~c;
      end
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_sub64_serial.sv
// Directed bench for sub64_serial: literal vectors plus a cycle-level
// arithmetic model compared against the outputs on every falling edge.
module tb_sub64_serial;
  localparam int NSLICE = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sub64_serial_if #(.WIDTH(64)) bus ();

  sub64_serial #(.WIDTH(64), .SLICE(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Model: an accepted start yields op1-op2 and (op1<op2) NSLICE edges later.
  logic [63:0] m_diff = '0, p_diff = '0;
  logic        m_bor = 1'b0, p_bor = 1'b0, m_done = 1'b0;
  int          rem = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_diff <= '0;
      m_bor  <= 1'b0;
      m_done <= 1'b0;
      rem    <= 0;
    end else begin
      m_done <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_diff <= p_diff;
          m_bor  <= p_bor;
          m_done <= 1'b1;
        end
      end else if (bus.start) begin
        p_diff <= bus.op1 - bus.op2;
        p_bor  <= (bus.op1 < bus.op2);
        rem    <= NSLICE;
      end
    end
  end

  always @(negedge clock) begin
    check("busy",   {63'd0, bus.busy},   {63'd0, rem > 0});
    check("done",   {63'd0, bus.done},   {63'd0, m_done});
    check("diff",   bus.diff,            m_diff);
    check("borrow", {63'd0, bus.borrow}, {63'd0, m_bor});
  end

  task automatic wait_done(output int cnt);
    bit found = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        cnt   = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_timeout act=no_done exp=done_within_30");
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) n++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_diff"},   bus.diff,            64'd0);
    check({tag, "_borrow"}, {63'd0, bus.borrow}, 64'd0);
    check({tag, "_busy"},   {63'd0, bus.busy},   64'd0);
    check({tag, "_done"},   {63'd0, bus.done},   64'd0);
  endtask

  task automatic run_op(input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] ed, input logic eb, input string tag);
    int cnt;
    @(negedge clock);
    bus.op1   = x;
    bus.op2   = y;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.op1   = ~x;
    bus.op2   = ~y;
    wait_done(cnt);
    check({tag, "_lat"},    64'(cnt),          64'd8);
    check({tag, "_diff"},   bus.diff,          ed);
    check({tag, "_borrow"}, {63'd0, bus.borrow}, {63'd0, eb});
  endtask

  logic [63:0] v_a [6] = '{64'h0000_0000_90AB_CDEF, 64'h0000_0000_1234_5678, 64'd0,
                           64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000};
  logic [63:0] v_b [6] = '{64'h0000_0000_1234_5678, 64'h0000_0000_90AB_CDEF, 64'd1,
                           64'hDEAD_BEEF_0123_4567, 64'd1, 64'd1};
  logic [63:0] v_d [6] = '{64'h0000_0000_7E77_7777, 64'hFFFF_FFFF_8188_8889, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
  logic        v_w [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int cnt, n;
    bus.start = 1'b0;
    bus.op1   = '0;
    bus.op2   = '0;

    // Reset held across an edge with start toggling.
    #1 reset = 1'b0;
    #1 check_zero("rst_a");
    bus.op1   = v_a[0];
    bus.op2   = v_b[0];
    bus.start = 1'b1;
    #5 check_zero("rst_b");
    bus.start = 1'b0;
    @(negedge clock);
    #3 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_zero("idle");

    for (int i = 0; i < 6; i++)
      run_op(v_a[i], v_b[i], v_d[i], v_w[i], $sformatf("vec%0d", i));

    // Start re-pulsed mid-run with other operands must be ignored.
    @(negedge clock);
    bus.op1 = v_a[0]; bus.op2 = v_b[0]; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    bus.op1 = v_a[1]; bus.op2 = v_b[1]; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(cnt);
    check("repulse_lat",  64'(cnt), 64'd5);
    check("repulse_diff", bus.diff, 64'h0000_0000_7E77_7777);
    count_dones(12, n);
    check("repulse_extra_done", 64'(n), 64'd0);

    // Start held high: back-to-back results every NSLICE+1 cycles.
    bus.op1 = v_a[0]; bus.op2 = v_b[0]; bus.start = 1'b1;
    @(negedge clock);
    bus.op1 = v_a[4]; bus.op2 = v_b[4];
    wait_done(cnt);
    check("held1_lat",  64'(cnt), 64'd8);
    check("held1_diff", bus.diff, 64'h0000_0000_7E77_7777);
    @(negedge clock);
    bus.op1 = v_a[2]; bus.op2 = v_b[2];
    wait_done(cnt);
    check("held2_period", 64'(cnt + 1), 64'd9);
    check("held2_diff",   bus.diff, 64'h7FFF_FFFF_FFFF_FFFF);
    bus.start = 1'b0;
    count_dones(12, n);
    check("held_extra_done", 64'(n), 64'd0);

    // Asynchronous reset in the fourth RUN cycle abandons the operation.
    bus.op1 = v_a[1]; bus.op2 = v_b[1]; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check("midrst_busy_before", {63'd0, bus.busy}, 64'd1);
    #2 reset = 1'b0;
    #1 check_zero("midrst");
    @(negedge clock);
    #3 reset = 1'b1;
    count_dones(12, n);
    check("midrst_no_done", 64'(n), 64'd0);
    run_op(v_a[4], v_b[4], v_d[4], v_w[4], "post_rst");

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
